// File: rtl/register_file_bank.sv
// General-purpose register bank: two combinational read ports with write bypass,
// one byte-enabled write port, r0 hardwired to zero, and a one-register-per-cycle clear sweep.
module register_file_bank #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [WIDTH/8-1:0]    wr_be,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  wr_drop
);
  localparam int NBYTES = WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0]      regs_q [DEPTH];
  logic [WIDTH-1:0]      regs_d [DEPTH];
  logic                  wr_valid;

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0]  old_v,
                                                   input logic [WIDTH-1:0]  new_v,
                                                   input logic [NBYTES-1:0] be);
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Writes to r0 are not real writes: they neither store nor count as dropped.
  assign wr_valid = wr_en && (wr_addr != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    case (state_q)
      IDLE: begin
        if (wr_valid) regs_d[wr_addr] = merge_lanes(regs_q[wr_addr], wr_data, wr_be);
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = FIRST_IDX;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        wr_drop_d     = wr_valid;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = FIRST_IDX;
        end else begin
          cnt_d = cnt_q + FIRST_IDX;
        end
      end
    endcase
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= FIRST_IDX;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass only while idle; during a sweep reads see the partially cleared storage.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (rd_addr_a == '0) rd_data_a = '0;
    else if (state_q == IDLE && wr_en && wr_addr == rd_addr_a)
      rd_data_a = merge_lanes(regs_q[rd_addr_a], wr_data, wr_be);
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (rd_addr_b == '0) rd_data_b = '0;
    else if (state_q == IDLE && wr_en && wr_addr == rd_addr_b)
      rd_data_b = merge_lanes(regs_q[rd_addr_b], wr_data, wr_be);
  end

  assign clr_busy = (state_q == CLEAR);
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_register_file_bank.sv
// Bench for register_file_bank: directed scenarios plus randomized traffic checked
// against an array-based model of the register bank and its clear sweep.
module tb_register_file_bank;
  localparam int WIDTH = 32, ADDR_WIDTH = 5, DEPTH = 32, NBE = WIDTH / 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [NBE-1:0]        wr_be;
  logic [ADDR_WIDTH-1:0] rd_addr_a, rd_addr_b;
  logic [WIDTH-1:0]      rd_data_a, rd_data_b;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  wr_drop;

  register_file_bank #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // Reference model: contents, whether a sweep is in progress, next register to sweep, drop flag.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_busy;
  int               m_sweep;
  bit               m_drop;
  int               n_tests = 0;
  int               n_fail  = 0;

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [NBE-1:0]   be);
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < NBE; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input logic [ADDR_WIDTH-1:0] a);
    if (a == 0) return '0;
    if (!m_busy && wr_en && wr_addr == a) return lane_merge(m_mem[a], wr_data, wr_be);
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy  = 0;
    m_sweep = 1;
    m_drop  = 0;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    clr_req = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [WIDTH-1:0] d, input logic [NBE-1:0] be);
    wr_en   = 1'b1;
    wr_addr = ADDR_WIDTH'(a);
    wr_data = d;
    wr_be   = be;
  endtask

  // Advance the model with the inputs presented now, then let the DUT take the same edge.
  task automatic tick();
    bit nd;
    nd = m_busy && wr_en && (wr_addr != 0);
    if (m_busy) begin
      m_mem[m_sweep] = '0;
      if (m_sweep == DEPTH - 1) begin
        m_busy  = 0;
        m_sweep = 1;
      end else begin
        m_sweep++;
      end
    end else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = lane_merge(m_mem[wr_addr], wr_data, wr_be);
      if (clr_req) begin
        m_busy  = 1;
        m_sweep = 1;
      end
    end
    m_drop = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_with_index();
    for (int i = 1; i < DEPTH; i++) begin
      do_write(i, WIDTH'(i), '1);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = ADDR_WIDTH'(a);
      rd_addr_b = ADDR_WIDTH'(DEPTH - 1 - a);
      #1;
      n_tests++;
      if (rd_data_a !== '0 || rd_data_b !== '0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got a=%h b=%h want 0", a, rd_data_a, rd_data_b);
      end
    end
    n_tests++;
    if (clr_busy !== 1'b0 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b drop=%b want 0 0", clr_busy, wr_drop);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_enable();
    do_write(5, 32'hDEADBEEF, 4'hF);
    tick();
    do_write(5, 32'h11223344, 4'b0101);
    tick();
    idle_inputs();
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd5;
    #1;
    n_tests++;
    if (rd_data_a !== 32'hDE22BE44 || rd_data_b !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL byte_enable got a=%h b=%h want de22be44", rd_data_a, rd_data_b);
    end
    do_write(5, 32'hFFFFFFFF, 4'h0);
    rd_addr_a = 5'd0;
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_data_b !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL be_zero_hold got %h want de22be44", rd_data_b);
    end
    do_write(0, 32'hFFFFFFFF, 4'hF);
    #1;
    n_tests++;
    if (rd_data_a !== '0) begin
      n_fail++;
      $display("FAIL r0_no_bypass got %h want 0", rd_data_a);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_data_a !== '0 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_write got rd=%h drop=%b want 0 0", rd_data_a, wr_drop);
    end
  endtask

  task automatic test_bypass();
    do_write(7, 32'hAAAAAAAA, 4'hF);
    tick();
    do_write(7, 32'h12345678, 4'b0011);
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd7;
    #1;
    n_tests++;
    if (rd_data_a !== 32'hAAAA5678 || rd_data_b !== 32'hAAAA5678) begin
      n_fail++;
      $display("FAIL bypass_pre got a=%h b=%h want aaaa5678", rd_data_a, rd_data_b);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (rd_data_a !== 32'hAAAA5678 || rd_data_b !== 32'hAAAA5678) begin
      n_fail++;
      $display("FAIL bypass_post got a=%h b=%h want aaaa5678", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_bulk_clear();
    int busy_cnt;
    fill_with_index();
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      rd_addr_a = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      rd_addr_b = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      if (c == 5) begin
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd30;
      end
      #1;
      if (clr_busy === 1'b1) busy_cnt++;
      n_tests++;
      if (rd_data_a !== model_read(rd_addr_a) || rd_data_b !== model_read(rd_addr_b)) begin
        n_fail++;
        $display("FAIL clear_read cyc=%0d got a=%h b=%h want %h %h", c, rd_data_a, rd_data_b,
                 model_read(rd_addr_a), model_read(rd_addr_b));
      end
      if (c == 5) begin
        n_tests++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd30) begin
          n_fail++;
          $display("FAIL mid_sweep got r3=%h r30=%h want 0 1e", rd_data_a, rd_data_b);
        end
      end
      tick();
    end
    n_tests++;
    if (busy_cnt != DEPTH - 1) begin
      n_fail++;
      $display("FAIL busy_len got %0d want %0d", busy_cnt, DEPTH - 1);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = ADDR_WIDTH'(a);
      #1;
      n_tests++;
      if (rd_data_a !== '0) begin
        n_fail++;
        $display("FAIL after_sweep addr=%0d got %h want 0", a, rd_data_a);
      end
    end
  endtask

  task automatic test_write_during_clear();
    int busy_cnt;
    do_write(9, 32'h77, 4'hF);
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      rd_addr_a = 5'd9;
      rd_addr_b = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      if (c == 3) do_write(9, 32'h55, 4'hF);
      if (c == 10) clr_req = 1'b1;
      #1;
      if (clr_busy === 1'b1) busy_cnt++;
      if (c == 3) begin
        n_tests++;
        if (rd_data_a !== 32'h77) begin
          n_fail++;
          $display("FAIL clear_no_bypass got %h want 77", rd_data_a);
        end
      end
      n_tests++;
      if (wr_drop !== m_drop || rd_data_b !== model_read(rd_addr_b)) begin
        n_fail++;
        $display("FAIL drop_seq cyc=%0d got drop=%b rd=%h want %b %h", c, wr_drop, rd_data_b,
                 m_drop, model_read(rd_addr_b));
      end
      if (c == 4) begin
        n_tests++;
        if (wr_drop !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_pulse got %b want 1", wr_drop);
        end
      end
      tick();
    end
    n_tests++;
    if (busy_cnt != DEPTH - 1) begin
      n_fail++;
      $display("FAIL busy_no_extend got %0d want %0d", busy_cnt, DEPTH - 1);
    end
    idle_inputs();
    rd_addr_a = 5'd9;
    #1;
    n_tests++;
    if (rd_data_a !== '0) begin
      n_fail++;
      $display("FAIL r9_swept got %h want 0", rd_data_a);
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill_with_index();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (clr_busy !== 1'b0 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags got busy=%b drop=%b want 0 0", clr_busy, wr_drop);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = ADDR_WIDTH'(a);
      #1;
      n_tests++;
      if (rd_data_a !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_read addr=%0d got %h want 0", a, rd_data_a);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_write(4, 32'hCAFEF00D, 4'hF);
    tick();
    idle_inputs();
    rd_addr_a = 5'd4;
    #1;
    n_tests++;
    if (rd_data_a !== 32'hCAFEF00D || wr_drop !== 1'b0 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_write got rd=%h drop=%b busy=%b want cafef00d 0 0",
               rd_data_a, wr_drop, clr_busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_addr   = ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      wr_data   = $urandom;
      wr_be     = NBE'($urandom);
      clr_req   = ($urandom_range(0, 59) == 0);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : ADDR_WIDTH'($urandom_range(0, DEPTH - 1));
      #1;
      n_tests++;
      if (rd_data_a !== model_read(rd_addr_a) || rd_data_b !== model_read(rd_addr_b) ||
          clr_busy !== m_busy || wr_drop !== m_drop) begin
        n_fail++;
        $display("FAIL random cyc=%0d got a=%h b=%h busy=%b drop=%b want %h %h %b %b", c,
                 rd_data_a, rd_data_b, clr_busy, wr_drop, model_read(rd_addr_a),
                 model_read(rd_addr_b), m_busy, m_drop);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle_inputs();
    test_reset();
    test_byte_enable();
    test_bypass();
    test_bulk_clear();
    test_write_during_clear();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
